// File: rtl/pcoeff_readout_accumulator_pkg.sv
// Shared constants and state type for the p-coefficient readout accumulator.
// This package stands in for the globals header: default collector address
// width, collector read latency and the readout FSM state encoding.
package pcoeff_readout_accumulator_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT  = 12;
  localparam int unsigned OUTPUT_READ_LATENCY = 5;
  localparam int unsigned SUMMED_DATA_WIDTH   = 38;
  localparam int unsigned PCOEFF_COUNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    PRA_IDLE,
    PRA_SWEEP,
    PRA_DRAIN,
    PRA_RESULT
  } praState_t;

  // Width of a down-counter that must hold values 0..maxVal.
  function automatic int unsigned counterWidth(input int unsigned maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/pcoeff_readout_accumulator_hyperpipe.sv
// Fixed-depth register pipeline (hyperpipe). Used here to carry the read
// valid tag alongside the collector read latency. Contents clear on reset.
module hyperpipe #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [CYCLES];

  // Shift din through CYCLES registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CYCLES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < CYCLES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[CYCLES-1];

endmodule

// File: rtl/pcoeff_readout_accumulator.sv
// Readout accumulator for the collection module. On start it sweeps every
// collector address once (each read wipes the entry), accumulates the
// returned summed data and p-coefficient counts, and offers one total per
// sweep on a valid/ready result port.
// Optional feature: define PCOEFF_ACCUM_OVERFLOW_CHECK_EN to report a sticky
// carry-out of the sum accumulator on resultOverflow; otherwise it is 0.
module pcoeff_readout_accumulator
  import pcoeff_readout_accumulator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int unsigned READ_LATENCY = OUTPUT_READ_LATENCY,
  parameter int unsigned SUM_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [37:0]           summedDataIn,
  input  logic [2:0]            pcoeffCountIn,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic [SUM_WIDTH-1:0]  resultSum,
  output logic [ADDR_WIDTH+2:0] resultCount,
  output logic                  resultOverflow
);

  localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 3;
  localparam int unsigned DRAIN_WIDTH = counterWidth(READ_LATENCY);

  praState_t              state;
  logic [SUM_WIDTH-1:0]   sumAcc;
  logic [CNT_WIDTH-1:0]   cntAcc;
  logic [DRAIN_WIDTH-1:0] drainCnt;
  logic                   tagIn;
  logic                   tagOut;
  logic [SUM_WIDTH-1:0]   sumAddend;
  logic [CNT_WIDTH-1:0]   cntAddend;
  logic [SUM_WIDTH-1:0]   sumNext;
  logic [CNT_WIDTH-1:0]   cntNext;
  logic                   drainDone;

  // One tag per issued read; it emerges exactly when that read's data arrives.
  assign tagIn = (state == PRA_SWEEP);

  hyperpipe #(
    .WIDTH  (1),
    .CYCLES (READ_LATENCY)
  ) validPipe (
    .clk  (clk),
    .rst  (rst),
    .din  (tagIn),
    .dout (tagOut)
  );

  assign sumAddend = tagOut ? SUM_WIDTH'(summedDataIn) : '0;
  assign cntAddend = tagOut ? CNT_WIDTH'(pcoeffCountIn) : '0;
  assign cntNext   = cntAcc + cntAddend;

`ifdef PCOEFF_ACCUM_OVERFLOW_CHECK_EN
  logic sumCarry;
  logic ovfSticky;

  assign {sumCarry, sumNext} = {1'b0, sumAcc} + {1'b0, sumAddend};
`else
  assign sumNext = sumAcc + sumAddend;
`endif

  // The last tag enters the pipe on the final SWEEP cycle, so the pipe is
  // empty exactly READ_LATENCY DRAIN cycles later; counting them out is
  // equivalent to watching the pipe drain.
  assign drainDone = (drainCnt == '0);

  // Readout FSM with registered outputs and accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PRA_IDLE;
      busy        <= 1'b0;
      readAddr    <= '0;
      resultValid <= 1'b0;
      resultSum   <= '0;
      resultCount <= '0;
      sumAcc      <= '0;
      cntAcc      <= '0;
      drainCnt    <= '0;
    end else begin
      case (state)
        PRA_IDLE: begin
          if (start) begin
            state    <= PRA_SWEEP;
            busy     <= 1'b1;
            readAddr <= '0;
            sumAcc   <= '0;
            cntAcc   <= '0;
          end
        end
        PRA_SWEEP: begin
          sumAcc <= sumNext;
          cntAcc <= cntNext;
          if (readAddr == '1) begin
            state    <= PRA_DRAIN;
            drainCnt <= DRAIN_WIDTH'(READ_LATENCY - 1);
          end else begin
            readAddr <= readAddr + 1'b1;
          end
        end
        PRA_DRAIN: begin
          sumAcc <= sumNext;
          cntAcc <= cntNext;
          if (drainDone) begin
            state       <= PRA_RESULT;
            resultValid <= 1'b1;
            resultSum   <= sumNext;
            resultCount <= cntNext;
          end else begin
            drainCnt <= drainCnt - 1'b1;
          end
        end
        PRA_RESULT: begin
          if (resultReady) begin
            state       <= PRA_IDLE;
            busy        <= 1'b0;
            resultValid <= 1'b0;
          end
        end
        default: state <= PRA_IDLE;
      endcase
    end
  end

`ifdef PCOEFF_ACCUM_OVERFLOW_CHECK_EN
  // Sticky sum carry, cleared at start and published with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfSticky      <= 1'b0;
      resultOverflow <= 1'b0;
    end else if (state == PRA_IDLE) begin
      if (start) ovfSticky <= 1'b0;
    end else if (state == PRA_SWEEP || state == PRA_DRAIN) begin
      if (sumCarry) ovfSticky <= 1'b1;
      if (state == PRA_DRAIN && drainDone) resultOverflow <= ovfSticky | sumCarry;
    end
  end
`else
  assign resultOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_pcoeff_readout_accumulator.sv
// Testbench for pcoeff_readout_accumulator with a wipe-on-read collector model
// (ADDR_WIDTH=10, READ_LATENCY=5). A second instance with SUM_WIDTH=40 shares
// all inputs and is checked for sum wrap and the overflow flag.
module tb_pcoeff_readout_accumulator;

  localparam int AW = 10;
  localparam int RL = 5;
  localparam int NE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          resultReady;
  logic [37:0]   summedDataIn;
  logic [2:0]    pcoeffCountIn;

  logic          busy, resultValid, resultOverflow;
  logic [AW-1:0] readAddr;
  logic [63:0]   resultSum;
  logic [AW+2:0] resultCount;

  logic          busy40, resultValid40, resultOverflow40;
  logic [AW-1:0] readAddr40;
  logic [39:0]   resultSum40;
  logic [AW+2:0] resultCount40;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcoeff_readout_accumulator #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .SUM_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .readAddr(readAddr),
    .summedDataIn(summedDataIn), .pcoeffCountIn(pcoeffCountIn),
    .resultValid(resultValid), .resultReady(resultReady), .resultSum(resultSum),
    .resultCount(resultCount), .resultOverflow(resultOverflow)
  );

  pcoeff_readout_accumulator #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .SUM_WIDTH(40)) dut40 (
    .clk(clk), .rst(rst), .start(start), .busy(busy40), .readAddr(readAddr40),
    .summedDataIn(summedDataIn), .pcoeffCountIn(pcoeffCountIn),
    .resultValid(resultValid40), .resultReady(resultReady), .resultSum(resultSum40),
    .resultCount(resultCount40), .resultOverflow(resultOverflow40)
  );

  // Collector model: memory contents written by tests, a read generation per
  // entry so a read wipes it, and a fixed-latency output delay line.
  logic [37:0] memSum [NE];
  logic [2:0]  memCnt [NE];
  int          gen = 1;
  int          readGen [NE];
  logic [40:0] rdWord;
  logic [40:0] dly [RL];
  int          logQ [$];

  always_comb begin
    rdWord = '0;
    if (busy && readGen[readAddr] != gen) rdWord = {memSum[readAddr], memCnt[readAddr]};
  end

  always @(posedge clk) begin
    if (busy) begin
      readGen[readAddr] <= gen;
      logQ.push_back(int'(readAddr));
    end
    dly[0] <= rdWord;
    for (int i = 1; i < RL; i++) dly[i] <= dly[i-1];
  end

  assign summedDataIn  = dly[RL-1][40:3];
  assign pcoeffCountIn = dly[RL-1][2:0];

  task automatic fillAll(input logic [37:0] s, input logic [2:0] c);
    for (int i = 0; i < NE; i++) begin
      memSum[i] = s;
      memCnt[i] = c;
    end
    gen++;
  endtask

  task automatic fillRandom();
    logic [63:0] r;
    for (int i = 0; i < NE; i++) begin
      r = {$urandom, $urandom};
      memSum[i] = r[37:0];
      memCnt[i] = 3'($urandom_range(6, 0));
    end
    gen++;
  endtask

  // Reference totals: plain sums over the collector contents.
  task automatic modelTotals(output longint unsigned s, output int c);
    s = 0;
    c = 0;
    for (int i = 0; i < NE; i++) begin
      s += longint'(memSum[i]);
      c += int'(memCnt[i]);
    end
  endtask

  function automatic logic expectOvf40(input longint unsigned s);
`ifdef PCOEFF_ACCUM_OVERFLOW_CHECK_EN
    return (s >> 40) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Caller is at a negedge. Pulses start, returns cycles until resultValid.
  task automatic runSweep(input int pulseAt, output int lat, output logic firstBusy,
                          output logic [AW-1:0] firstAddr, output logic busyDropped);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    firstBusy = busy;
    firstAddr = readAddr;
    busyDropped = 1'b0;
    while (resultValid !== 1'b1 && lat < 3000) begin
      if (lat == pulseAt) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy !== 1'b1) busyDropped = 1'b1;
    end
  endtask

  task automatic handshake(input int delay);
    repeat (delay) @(negedge clk);
    resultReady = 1'b1;
    @(negedge clk);
    resultReady = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (readAddr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", readAddr); end
    checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", resultValid); end
    checks++; if (resultSum !== '0) begin errors++; $display("FAIL reset_sum got %0h want 0", resultSum); end
    checks++; if (resultCount !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", resultCount); end
    checks++; if (resultOverflow40 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", resultOverflow40); end
  endtask

  task automatic test_zero();
    int lat; logic fb; logic [AW-1:0] fa; logic bd;
    fillAll('0, '0);
    runSweep(0, lat, fb, fa, bd);
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL zero_busy_c1 got %0b want 1", fb); end
    checks++; if (fa !== '0) begin errors++; $display("FAIL zero_addr_c1 got %0d want 0", fa); end
    checks++; if (lat != 1030) begin errors++; $display("FAIL zero_latency got %0d want 1030", lat); end
    checks++; if (resultSum !== 64'd0) begin errors++; $display("FAIL zero_sum got %0h want 0", resultSum); end
    checks++; if (resultCount !== '0) begin errors++; $display("FAIL zero_count got %0d want 0", resultCount); end
    handshake(0);
    checks++; if (resultValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after_hs valid=%0b busy=%0b want 0 0", resultValid, busy);
    end
  endtask

  task automatic test_ones();
    int lat; logic fb; logic [AW-1:0] fa; logic bd; int logStart; int bad;
    fillAll(38'd1, 3'd1);
    logStart = logQ.size();
    runSweep(0, lat, fb, fa, bd);
    checks++; if (resultSum !== 64'd1024) begin errors++; $display("FAIL ones_sum got %0d want 1024", resultSum); end
    checks++; if (resultCount !== 13'd1024) begin errors++; $display("FAIL ones_count got %0d want 1024", resultCount); end
    handshake(1);
    bad = 0;
    for (int i = logStart; i < logQ.size(); i++)
      if (logQ[i] != ((i - logStart < NE) ? (i - logStart) : NE - 1)) bad++;
    if (logQ.size() - logStart < NE) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ones_read_order bad=%0d want 0", bad); end
  endtask

  task automatic test_single_and_back_to_back();
    int lat; logic fb; logic [AW-1:0] fa; logic bd;
    fillAll('0, '0);
    memSum[5] = 38'h20_0000_0000;
    memCnt[5] = 3'd1;
    runSweep(0, lat, fb, fa, bd);
    checks++; if (resultSum !== 64'h20_0000_0000) begin errors++; $display("FAIL single_sum got %0h want 2000000000", resultSum); end
    checks++; if (resultCount !== 13'd1) begin errors++; $display("FAIL single_count got %0d want 1", resultCount); end
    handshake(0);
    // start in the cycle right after the handshake; entries were wiped
    runSweep(0, lat, fb, fa, bd);
    checks++; if (lat != 1030) begin errors++; $display("FAIL b2b_latency got %0d want 1030", lat); end
    checks++; if (resultSum !== 64'd0 || resultCount !== '0) begin
      errors++; $display("FAIL b2b_wiped sum=%0h count=%0d want 0 0", resultSum, resultCount);
    end
    handshake(0);
  endtask

  task automatic test_hold();
    int lat; logic fb; logic [AW-1:0] fa; logic bd; logic [63:0] s0; logic [AW+2:0] c0;
    logic unstable; logic busyBack;
    fillAll(38'd3, 3'd2);
    runSweep(100, lat, fb, fa, bd);
    checks++; if (lat != 1030) begin errors++; $display("FAIL hold_latency got %0d want 1030", lat); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL hold_busy_drop got %0b want 0", bd); end
    s0 = resultSum; c0 = resultCount; unstable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (resultValid !== 1'b1 || busy !== 1'b1 || resultSum !== s0 || resultCount !== c0) unstable = 1'b1;
    end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL hold_stable got %0b want 0", unstable); end
    checks++; if (s0 !== 64'd3072 || c0 !== 13'd2048) begin
      errors++; $display("FAIL hold_value sum=%0d count=%0d want 3072 2048", s0, c0);
    end
    handshake(0);
    busyBack = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || resultValid !== 1'b0) busyBack = 1'b1;
    end
    checks++; if (busyBack !== 1'b0) begin errors++; $display("FAIL hold_no_queued_start got %0b want 0", busyBack); end
  endtask

  task automatic test_reset_mid();
    int n; int lat; logic fb; logic [AW-1:0] fa; logic bd;
    fillAll(38'd7, 3'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (readAddr != 10'd300 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin errors++; $display("FAIL rstmid_reach_300 got %0d want <1000", n); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || readAddr !== '0 || resultValid !== 1'b0 || resultSum !== '0 ||
                  resultCount !== '0 || resultOverflow !== 1'b0 || resultOverflow40 !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs busy=%0b addr=%0d valid=%0b sum=%0h cnt=%0d want all 0",
                         busy, readAddr, resultValid, resultSum, resultCount);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fillAll(38'd2, 3'd1);
    runSweep(0, lat, fb, fa, bd);
    checks++; if (resultSum !== 64'd2048 || resultCount !== 13'd1024) begin
      errors++; $display("FAIL rstmid_sum sum=%0d count=%0d want 2048 1024", resultSum, resultCount);
    end
    handshake(0);
  endtask

  task automatic test_overflow();
    int lat; logic fb; logic [AW-1:0] fa; logic bd; logic expOv;
    fillAll(38'h20_0000_0000, 3'd0);
    expOv = expectOvf40(64'h8000_0000_0000);
    runSweep(0, lat, fb, fa, bd);
    checks++; if (resultSum40 !== 40'd0) begin errors++; $display("FAIL ovf_sum40 got %0h want 0", resultSum40); end
    checks++; if (resultOverflow40 !== expOv) begin errors++; $display("FAIL ovf_flag40 got %0b want %0b", resultOverflow40, expOv); end
    checks++; if (resultSum !== 64'h8000_0000_0000 || resultOverflow !== 1'b0) begin
      errors++; $display("FAIL ovf_sum64 sum=%0h ovf=%0b want 800000000000 0", resultSum, resultOverflow);
    end
    handshake(2);
  endtask

  task automatic test_random();
    int lat; logic fb; logic [AW-1:0] fa; logic bd;
    longint unsigned es; int ec; logic [63:0] es64; logic [39:0] es40;
    for (int it = 0; it < 3; it++) begin
      fillRandom();
      modelTotals(es, ec);
      es64 = es;
      es40 = es64[39:0];
      runSweep(0, lat, fb, fa, bd);
      checks++; if (resultSum !== es64 || resultCount !== 13'(ec)) begin
        errors++; $display("FAIL rand%0d_64 sum=%0h cnt=%0d want %0h %0d", it, resultSum, resultCount, es64, ec);
      end
      checks++; if (resultSum40 !== es40 || resultOverflow40 !== expectOvf40(es)) begin
        errors++; $display("FAIL rand%0d_40 sum=%0h ovf=%0b want %0h %0b", it, resultSum40, resultOverflow40,
                           es40, expectOvf40(es));
      end
      handshake(int'($urandom_range(5, 0)));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    resultReady = 1'b0;
    fillAll('0, '0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_zero();
    test_ones();
    test_single_and_back_to_back();
    test_hold();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcoeff_readout_accumulator.md
# pcoeff_readout_accumulator

Downstream stage of the collection module. On command it sweeps the full collector address space via `readAddr`. It accumulates the per-address summed p-coefficient value and p-coefficient count that come back after the fixed read latency, then presents one total per sweep on a valid/ready result port. The sweep reads every entry once, and each read also wipes that entry, so the collector is left empty for the next top.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (12): collector address width; legal range 10..13.
- `READ_LATENCY`, default `` `OUTPUT_READ_LATENCY ``: cycles from `readAddr` to matching `summedDataIn`/`pcoeffCountIn`; must be ≥ 2.
- `SUM_WIDTH`, default 64: accumulator and `resultSum` width; must be ≥ 38.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous active-high reset.
- `start`, input, 1: begin a sweep; honoured only in IDLE.
- `busy`, output, 1: high in every state except IDLE; upstream must not write while high.
- `readAddr`, output, `ADDR_WIDTH`: registered address to the collector.
- `summedDataIn`, input, 38: collector summed data.
- `pcoeffCountIn`, input, 3: collector count, 0..6.
- `resultValid`, output, 1: result available.
- `resultReady`, input, 1: consumer accepts result.
- `resultSum`, output, `SUM_WIDTH`: total of `summedDataIn` over the sweep.
- `resultCount`, output, `ADDR_WIDTH+3`: total of `pcoeffCountIn` over the sweep.
- `resultOverflow`, output, 1: sum overflow flag (see Configuration).

## Operation
- States: IDLE, SWEEP, DRAIN, RESULT.
- IDLE: `start`=1 → SWEEP. The accumulators clear to 0 and `readAddr` is set to 0.
- SWEEP:
  - `readAddr` increments by 1 every cycle and a tag bit enters a `READ_LATENCY`-deep valid pipe.
  - At `readAddr` = 2^ADDR_WIDTH−1 → DRAIN; `readAddr` holds that value.
- DRAIN: waits until the valid pipe is empty, then → RESULT.
- Accumulation: each cycle the pipe output tag is 1, `sumAcc += zero-extend(summedDataIn)` and `cntAcc += pcoeffCountIn`.
- Width rules:
  - `cntAcc` (`ADDR_WIDTH+3` bits) cannot overflow, since the maximum is 6·2^ADDR_WIDTH.
  - `sumAcc` wraps modulo 2^SUM_WIDTH.
- RESULT:
  - `resultValid`=1; `resultSum`, `resultCount` and `resultOverflow` are stable until the handshake.
  - `resultValid`·`resultReady` → IDLE; `resultValid` goes 0 the next cycle.
- `start` in any state other than IDLE is ignored and not queued.
- Reset values: state IDLE, `busy`=0, `readAddr`=0, `resultValid`=0, `resultSum`=0, `resultCount`=0, `resultOverflow`=0, valid pipe cleared.
- Reset mid-operation: the sweep is abandoned with no partial result. The remaining collector entries are not wiped by this block.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: `busy`=1 and `readAddr`=0.
- Cycle 1+a: `readAddr`=a for a in 0..2^ADDR_WIDTH−1.
- Data for address a is sampled at cycle 1+a+`READ_LATENCY`.
- The last sample is at cycle 2^ADDR_WIDTH+`READ_LATENCY`; `resultValid`=1 at cycle 2^ADDR_WIDTH+`READ_LATENCY`+1.
- Back-to-back: `start` may be asserted in the cycle after the handshake (IDLE).
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro: `PCOEFF_ACCUM_OVERFLOW_CHECK_EN`.
- Defined: the carry out of the `sumAcc` adder sets a sticky flag. The flag clears at `start` and appears as `resultOverflow` in RESULT.
- Undefined: there is no carry logic and `resultOverflow` is tied to 0.

## Structure
- Shared package/header (`pipelineGlobals.vh`):
  - `ADDR_WIDTH` and `OUTPUT_READ_LATENCY`.
  - New state encoding constants `PRA_IDLE`, `PRA_SWEEP`, `PRA_DRAIN`, `PRA_RESULT`.
- Sub-module: the existing `hyperpipe` (WIDTH=1, CYCLES=`READ_LATENCY`) carries the valid tag. Everything else stays inline.

## Test plan
All scenarios use a collector model with `ADDR_WIDTH`=10 and `READ_LATENCY`=5.
1. All entries are 0; pulse `start` at cycle 0 → `resultValid` at cycle 1030, `resultSum`=0, `resultCount`=0.
2. Every entry is summed=1, count=1 → `resultSum`=1024, `resultCount`=1024; each address is read exactly once, in the order 0..1023.
3. Only address 5 holds summed=0x20_0000_0000, count=1 → `resultSum`=0x20_0000_0000, `resultCount`=1.
4. `resultReady` held low 10 cycles, with `start` pulsed during SWEEP and during RESULT → result stable, one result only, `busy` stays 1 until the handshake.
5. `rst` asserted at `readAddr`=300, then `start` with all entries summed=2 → all outputs show their reset values during reset; after that, `resultSum`=2048.
6. `SUM_WIDTH`=40 and every entry summed=2^37 → with the macro defined, `resultOverflow`=1 and `resultSum`=0; with it undefined, `resultOverflow`=0 and `resultSum`=0.
